// File: rtl/irq_controller_if.sv
// IO-bus and CPU handshake bundle for the interrupt controller.
interface irq_controller_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic       irq;
  logic [1:0] irq_vector;
  logic       irq_ack;
  logic       reti;

  modport master (
    output din, address, w_en, r_en,
    output irq_ack, reti,
    input  dout, irq, irq_vector
  );

  modport slave (
    input  din, address, w_en, r_en,
    input  irq_ack, reti,
    output dout, irq, irq_vector
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-latched, fixed-priority interrupt controller with IO-mapped regs.
// IRQ_CTRL_AUTO_CLR_EN: pulse flags_clr to the acked source.
module irq_controller #(
  parameter logic [7:0] IRQ_CTRL_ADDRESS = 8'h90
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_controller_if.slave  bus,
  input  logic [3:0]       flags,
  output logic [3:0]       flags_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ie_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] flag_q;
  logic       armed_q;
  logic       irq_q, irq_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] dout_q, dout_d;

  logic [3:0] rise, clr, elig;
  logic [1:0] win;
  logic       ack_fire;
  logic       wr_ie, wr_pend;

  assign wr_ie   = bus.w_en &&
                   (bus.address == IRQ_CTRL_ADDRESS);
  assign wr_pend = bus.w_en &&
                   (bus.address == IRQ_CTRL_ADDRESS + 8'd1);

  // A flag already high at reset release must not count as an edge
  assign rise = flags & ~flag_q & {4{armed_q}};
  assign elig = pend_q & ie_q[3:0] & {4{ie_q[7]}};

  always_comb begin
    if (elig[0])      win = 2'd0;
    else if (elig[1]) win = 2'd1;
    else if (elig[2]) win = 2'd2;
    else              win = 2'd3;
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    ack_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          vec_d   = win;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          ack_fire = 1'b1;
          state_d  = SERVICE;
        end else if (!elig[vec_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.reti) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == REQ);
  end

  // New edges win over any clear landing in the same cycle
  always_comb begin
    clr = '0;
    if (wr_pend) clr = bus.din[3:0];
    if (ack_fire) clr[vec_q] = 1'b1;
    pend_d = (pend_q & ~clr) | rise;
  end

  always_comb begin
    dout_d = '0;
    if (bus.r_en) begin
      if (bus.address == IRQ_CTRL_ADDRESS)
        dout_d = ie_q;
      else if (bus.address == IRQ_CTRL_ADDRESS + 8'd1)
        dout_d = {4'b0, pend_q};
      else if (bus.address == IRQ_CTRL_ADDRESS + 8'd2)
        dout_d = {state_q == SERVICE, irq_q, 4'b0, vec_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ie_q    <= '0;
      pend_q  <= '0;
      flag_q  <= '0;
      armed_q <= 1'b0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_ie) ie_q <= bus.din & 8'h8F;
      pend_q  <= pend_d;
      flag_q  <= flags;
      armed_q <= 1'b1;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
      dout_q  <= dout_d;
    end
  end

`ifdef IRQ_CTRL_AUTO_CLR_EN
  logic [3:0] clr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_q <= '0;
    else        clr_q <= ack_fire ? (4'b1 << vec_q) : 4'b0;
  end

  assign flags_clr = clr_q;
`else
  assign flags_clr = 4'b0;
`endif

  assign bus.irq        = irq_q;
  assign bus.irq_vector = vec_q;
  assign bus.dout       = dout_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed vector bench for irq_controller.
module tb_irq_controller;

`ifdef IRQ_CTRL_AUTO_CLR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] flags;
  logic [3:0] flags_clr;
  int         errors = 0;
  int         checks = 0;

  irq_controller_if bus ();

  irq_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .flags     (flags),
    .flags_clr (flags_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] din;
    logic [3:0] fl;
    logic       ack;
    logic       reti;
    logic       irq;
    logic [1:0] vec;
    logic [7:0] dout;
    logic [3:0] clr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic we, input logic re,
    input logic [7:0] addr, input logic [7:0] din,
    input logic [3:0] fl, input logic ack,
    input logic reti, input logic irq,
    input logic [1:0] vec, input logic [7:0] dout,
    input logic [3:0] clr
  );
    vec_t v;
    v = '{we, re, addr, din, fl, ack, reti,
          irq, vec, dout, clr};
    tbl.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic we, input logic re,
    input logic [7:0] addr, input logic [7:0] din,
    input logic [3:0] fl, input logic ack,
    input logic reti
  );
    bus.w_en    = we;
    bus.r_en    = re;
    bus.address = addr;
    bus.din     = din;
    flags       = fl;
    bus.irq_ack = ack;
    bus.reti    = reti;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 4'h0, 0, 0);
    #1;
    chk("rst irq", {31'b0, bus.irq}, 0);
    chk("rst vec", {30'b0, bus.irq_vector}, 0);
    chk("rst dout", {24'b0, bus.dout}, 0);
    chk("rst clr", {28'b0, flags_clr}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    //   we re addr   din    fl    ak rt irq vec dout  clr
    add(1, 0, 8'h90, 8'h81, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0);
    add(0, 1, 8'h90, 8'h00, 4'h1, 0, 0, 0, 0, 8'h81, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h1, 0, 0, 1, 0, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h1, 1, 0, 0, 0, 8'h00, 4'h1);
    add(0, 1, 8'h92, 8'h00, 4'h1, 0, 0, 0, 0, 8'h80, 4'h0);
    add(0, 1, 8'h91, 8'h00, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h0, 0, 1, 0, 0, 8'h00, 4'h0);
    add(1, 0, 8'h90, 8'h8F, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'hA, 0, 0, 0, 0, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'hA, 0, 0, 1, 1, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'hA, 1, 0, 0, 1, 8'h00, 4'h2);
    add(0, 1, 8'h92, 8'h00, 4'hA, 0, 0, 0, 1, 8'h81, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'hA, 0, 1, 0, 1, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'hA, 0, 0, 1, 3, 8'h00, 4'h0);
    add(0, 1, 8'h92, 8'h00, 4'hA, 0, 0, 1, 3, 8'h43, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'hA, 1, 0, 0, 3, 8'h00, 4'h8);
    add(0, 0, 8'h00, 8'h00, 4'h0, 0, 1, 0, 3, 8'h00, 4'h0);
    add(1, 0, 8'h90, 8'h04, 4'h0, 0, 0, 0, 3, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h4, 0, 0, 0, 3, 8'h00, 4'h0);
    add(0, 1, 8'h91, 8'h00, 4'h4, 0, 0, 0, 3, 8'h04, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h4, 0, 0, 0, 3, 8'h00, 4'h0);
    add(1, 0, 8'h90, 8'h84, 4'h4, 0, 0, 0, 3, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h4, 0, 0, 1, 2, 8'h00, 4'h0);
    add(0, 1, 8'h90, 8'h00, 4'h4, 0, 0, 1, 2, 8'h84, 4'h0);
    add(1, 0, 8'h91, 8'h04, 4'h4, 0, 0, 1, 2, 8'h00, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h4, 0, 0, 0, 2, 8'h00, 4'h0);
    add(0, 1, 8'h92, 8'h00, 4'h4, 0, 0, 0, 2, 8'h02, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 2, 8'h00, 4'h0);
    add(1, 0, 8'h91, 8'h04, 4'h4, 0, 0, 0, 2, 8'h00, 4'h0);
    add(0, 1, 8'h91, 8'h00, 4'h4, 0, 0, 1, 2, 8'h04, 4'h0);
    add(0, 0, 8'h00, 8'h00, 4'h4, 1, 0, 0, 2, 8'h00, 4'h4);
    add(0, 0, 8'h00, 8'h00, 4'h4, 0, 1, 0, 2, 8'h00, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].din,
            tbl[i].fl, tbl[i].ack, tbl[i].reti);
      step();
      chk($sformatf("row%0d irq", i),
          {31'b0, bus.irq}, {31'b0, tbl[i].irq});
      chk($sformatf("row%0d vec", i),
          {30'b0, bus.irq_vector}, {30'b0, tbl[i].vec});
      chk($sformatf("row%0d dout", i),
          {24'b0, bus.dout}, {24'b0, tbl[i].dout});
      chk($sformatf("row%0d clr", i),
          {28'b0, flags_clr},
          {28'b0, AUTO ? tbl[i].clr : 4'h0});
    end

    // Async reset while in SERVICE with a non-zero vector
    drive(1, 0, 8'h90, 8'h82, 4'h0, 0, 0);
    step();
    drive(0, 0, 8'h00, 8'h00, 4'h2, 0, 0);
    step();
    step();
    chk("seq irq before ack", {31'b0, bus.irq}, 1);
    drive(0, 0, 8'h00, 8'h00, 4'h2, 1, 0);
    step();
    drive(0, 1, 8'h92, 8'h00, 4'h2, 0, 0);
    step();
    chk("seq status svc", {24'b0, bus.dout}, 32'h81);
    drive(0, 0, 8'h00, 8'h00, 4'h2, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async irq", {31'b0, bus.irq}, 0);
    chk("async vec", {30'b0, bus.irq_vector}, 0);
    chk("async dout", {24'b0, bus.dout}, 0);
    chk("async clr", {28'b0, flags_clr}, 0);
    step();
    #3;
    rst_n = 1'b1;
    step();
    step();
    drive(0, 1, 8'h91, 8'h00, 4'h2, 0, 0);
    step();
    chk("held flag pend", {24'b0, bus.dout}, 0);
    drive(0, 1, 8'h90, 8'h00, 4'h2, 0, 0);
    step();
    chk("ie after rst", {24'b0, bus.dout}, 0);
    chk("held flag irq", {31'b0, bus.irq}, 0);

    // Flag must fall and rise again before it counts
    drive(1, 0, 8'h90, 8'h82, 4'h2, 0, 0);
    step();
    step();
    chk("held flag no irq", {31'b0, bus.irq}, 0);
    drive(0, 0, 8'h00, 8'h00, 4'h0, 0, 0);
    step();
    drive(0, 0, 8'h00, 8'h00, 4'h2, 0, 0);
    step();
    step();
    chk("rearm irq", {31'b0, bus.irq}, 1);
    chk("rearm vec", {30'b0, bus.irq_vector}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
